// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle for the multicycle RISC-V core.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes ALU and immediate selects, stalling on memory handshakes.
module multicycle_controller (
    input logic                        clk,
    input logic                        rst,
    multicycle_controller_if.master    bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StIllegal  = 4'd11
    } state_e;

    state_e     state_q, state_d, st;
    logic [1:0] alu_op;
    logic [1:0] imm_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        unique case (bus.op)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_d           = StFetch;
        alu_op            = 2'b00;
        bus.mem_req       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ResultSrc     = 2'b00;
        bus.ALUSrcA       = 2'b00;
        bus.ALUSrcB       = 2'b00;
        bus.ImmSrc        = imm_src;
        bus.illegal_instr = 1'b0;
        // Outputs under reset present FETCH, with the side-effecting strobes masked below.
        st = rst ? StFetch : state_q;

        case (st)
            StFetch: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                state_d       = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                unique case (bus.op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b1100011:             state_d = StBeq;
                    7'b1101111:             state_d = StJal;
                    default:                state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_d     = (bus.op == 7'b0000011) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                state_d     = bus.mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            StMemWrite: begin
                bus.mem_req  = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                state_d      = bus.mem_ready ? StFetch : StMemWrite;
            end
            StExecR, StExecI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = (st == StExecI) ? 2'b01 : 2'b00;
                alu_op      = 2'b10;
                state_d     = StAluWb;
            end
            StAluWb: begin
                bus.RegWrite = 1'b1;
            end
            StBeq: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b01;
                bus.PCWrite = bus.zero;
            end
            StJal: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                state_d     = StAluWb;
            end
            StIllegal: begin
                bus.illegal_instr = 1'b1;
            end
            default: begin
                bus.ImmSrc = 2'b00;
            end
        endcase

        if (rst) begin
            bus.mem_req = 1'b0;
            bus.IRWrite = 1'b0;
            bus.PCWrite = 1'b0;
        end
    end

    always_comb begin
        unique case (alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                unique case (bus.funct3)
                    3'b000:  bus.ALUControl = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001
                                                                                   : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    assign bus.state = state_q;

endmodule
